// File: rtl/byte_unstriping_2l_pkg.sv
// Shared PHY receive-path definitions.
// Lane state encoding and common byte constants.
package byte_unstriping_2l_pkg;

  localparam int PHY_DATA_W = 8;

  localparam logic [7:0] COMMA_BYTE = 8'hBC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/byte_unstriping_2l_if.sv
// Two-lane receive bundle and recombined byte stream.
// The master drives lanes; the slave (unstriper) drives the output side.
interface byte_unstriping_2l_if
  import byte_unstriping_2l_pkg::*;
#(
  parameter int DATA_W = PHY_DATA_W,
  parameter int CNT_W  = 16
);

  logic [DATA_W-1:0] lane0_data;
  logic              lane0_valid;
  logic [DATA_W-1:0] lane1_data;
  logic              lane1_valid;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              err_out;
  logic              active;
  logic [CNT_W-1:0]  byte_count;

  modport master (
    output lane0_data,
    output lane0_valid,
    output lane1_data,
    output lane1_valid,
    input  data_out,
    input  valid_out,
    input  err_out,
    input  active,
    input  byte_count
  );

  modport slave (
    input  lane0_data,
    input  lane0_valid,
    input  lane1_data,
    input  lane1_valid,
    output data_out,
    output valid_out,
    output err_out,
    output active,
    output byte_count
  );

endinterface

// File: rtl/byte_unstriping_2l.sv
// Merges two clk_f byte lanes into one clk_2f byte stream,
// lane0 first, with lane-order error flag and delivered-byte count.
module byte_unstriping_2l
  import byte_unstriping_2l_pkg::*;
#(
  parameter int DATA_W = PHY_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic clk_2f,
  input  logic reset,
  byte_unstriping_2l_if.slave bus
);

  state_t            state, state_nx;
  logic              phase, phase_nx;
  logic [DATA_W-1:0] hold_d, hold_d_nx;
  logic              hold_v, hold_v_nx;
  logic [DATA_W-1:0] dout, dout_nx;
  logic              vout, vout_nx;
  logic              err, err_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              capture;

  // IDLE and RUN/phase 0 share the same lane sampling step
  assign capture = (state == ST_IDLE) || !phase;

  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    hold_d_nx = hold_d;
    hold_v_nx = hold_v;
    dout_nx   = '0;
    vout_nx   = 1'b0;
    err_nx    = 1'b0;
    if (capture) begin
      if (bus.lane0_valid) begin
        hold_d_nx = bus.lane1_data;
        hold_v_nx = bus.lane1_valid;
        dout_nx   = bus.lane0_data;
        vout_nx   = 1'b1;
        state_nx  = ST_RUN;
        phase_nx  = 1'b1;
      end else begin
        state_nx  = ST_IDLE;
        phase_nx  = 1'b0;
        err_nx    = bus.lane1_valid;
      end
    end else if (hold_v) begin
      dout_nx  = hold_d;
      vout_nx  = 1'b1;
      phase_nx = 1'b0;
    end else begin
      state_nx = ST_IDLE;
      phase_nx = 1'b0;
    end
    cnt_nx = cnt;
    if (vout_nx && (cnt != '1)) begin
      cnt_nx = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      state  <= ST_IDLE;
      phase  <= 1'b0;
      hold_d <= '0;
      hold_v <= 1'b0;
      dout   <= '0;
      vout   <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      phase  <= phase_nx;
      hold_d <= hold_d_nx;
      hold_v <= hold_v_nx;
      dout   <= dout_nx;
      vout   <= vout_nx;
      err    <= err_nx;
      cnt    <= cnt_nx;
    end
  end

  assign bus.data_out   = dout;
  assign bus.valid_out  = vout;
  assign bus.err_out    = err;
  assign bus.active     = (state == ST_RUN);
  assign bus.byte_count = cnt;

endmodule

// File: tb/tb_byte_unstriping_2l.sv
// Bench for byte_unstriping_2l: vector table, corner sequences,
// and a scoreboarded stream driving a full-width and a 4-bit-count DUT.
module tb_byte_unstriping_2l;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       l0v = 1'b0;
  logic [7:0] l0d = '0;
  logic       l1v = 1'b0;
  logic [7:0] l1d = '0;

  int checks = 0;
  int errors = 0;
  int seen   = 0;
  bit mon_en = 1'b0;
  logic [7:0] sbq[$];

  always #5 clk = ~clk;

  byte_unstriping_2l_if #(.DATA_W(8), .CNT_W(16)) bus16 ();
  byte_unstriping_2l_if #(.DATA_W(8), .CNT_W(4))  bus4 ();

  assign bus16.lane0_data  = l0d;
  assign bus16.lane0_valid = l0v;
  assign bus16.lane1_data  = l1d;
  assign bus16.lane1_valid = l1v;
  assign bus4.lane0_data   = l0d;
  assign bus4.lane0_valid  = l0v;
  assign bus4.lane1_data   = l1d;
  assign bus4.lane1_valid  = l1v;

  byte_unstriping_2l #(.DATA_W(8), .CNT_W(16)) dut16 (
    .clk_2f(clk),
    .reset (rst),
    .bus   (bus16)
  );

  byte_unstriping_2l #(.DATA_W(8), .CNT_W(4)) dut4 (
    .clk_2f(clk),
    .reset (rst),
    .bus   (bus4)
  );

  typedef struct {
    logic       l0v;
    logic [7:0] l0d;
    logic       l1v;
    logic [7:0] l1d;
    logic       v;
    logic [7:0] d;
    logic       e;
    logic       a;
    int         c;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lanes(logic a, logic [7:0] ad, logic b, logic [7:0] bd);
    l0v = a;
    l0d = ad;
    l1v = b;
    l1d = bd;
  endtask

  task automatic outs(string n, logic v, logic [7:0] d, logic e,
                      logic a, int c);
    chk({n, " valid"}, 32'(bus16.valid_out), 32'(v));
    chk({n, " data"},  32'(bus16.data_out),  32'(d));
    chk({n, " err"},   32'(bus16.err_out),   32'(e));
    chk({n, " active"}, 32'(bus16.active),   32'(a));
    chk({n, " count"}, 32'(bus16.byte_count), 32'(c));
  endtask

  task automatic do_reset();
    lanes(1'b0, 8'h00, 1'b0, 8'h00);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus16.valid_out === 1'b1) begin
        seen++;
        if (sbq.size() == 0) begin
          chk("sb unexpected byte", 32'(bus16.data_out), 32'hFFFF_FFFF);
        end else begin
          chk("sb data", 32'(bus16.data_out), 32'(sbq.pop_front()));
        end
      end
      chk("sb count16", 32'(bus16.byte_count), 32'(seen));
      chk("sb count4", 32'(bus4.byte_count), 32'((seen > 15) ? 15 : seen));
    end
  end

  initial begin
    tbl[0]  = '{1, 8'h01, 1, 8'h02, 1, 8'h01, 0, 1, 1};
    tbl[1]  = '{1, 8'h01, 1, 8'h02, 1, 8'h02, 0, 1, 2};
    tbl[2]  = '{1, 8'h03, 1, 8'h04, 1, 8'h03, 0, 1, 3};
    tbl[3]  = '{1, 8'h03, 1, 8'h04, 1, 8'h04, 0, 1, 4};
    tbl[4]  = '{0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 4};
    tbl[5]  = '{0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 4};
    tbl[6]  = '{1, 8'h10, 1, 8'h11, 1, 8'h10, 0, 1, 5};
    tbl[7]  = '{1, 8'h10, 1, 8'h11, 1, 8'h11, 0, 1, 6};
    tbl[8]  = '{1, 8'h12, 0, 8'h00, 1, 8'h12, 0, 1, 7};
    tbl[9]  = '{1, 8'h12, 0, 8'h00, 0, 8'h00, 0, 0, 7};
    tbl[10] = '{0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 7};
    tbl[11] = '{0, 8'h00, 1, 8'h77, 0, 8'h00, 1, 0, 7};
    tbl[12] = '{0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 7};
    tbl[13] = '{1, 8'h30, 1, 8'h31, 1, 8'h30, 0, 1, 8};
    tbl[14] = '{1, 8'h30, 1, 8'h31, 1, 8'h31, 0, 1, 9};
    tbl[15] = '{0, 8'h00, 1, 8'h99, 0, 8'h00, 1, 0, 9};
    tbl[16] = '{0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 9};

    // reset held with both lanes valid
    rst = 1'b0;
    lanes(1'b1, 8'hAA, 1'b1, 8'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      outs($sformatf("rst%0d", i), 0, 8'h00, 0, 0, 0);
    end
    rst = 1'b1;
    tick();
    outs("rst release", 1, 8'hAA, 0, 1, 1);
    tick();
    outs("rst lane1", 1, 8'h55, 0, 1, 2);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      lanes(tbl[i].l0v, tbl[i].l0d, tbl[i].l1v, tbl[i].l1d);
      tick();
      outs($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].e,
           tbl[i].a, tbl[i].c);
    end

    // reset right after lane0 byte: held lane1 byte must be dropped
    lanes(1'b1, 8'h20, 1'b1, 8'h21);
    tick();
    outs("mid 20", 1, 8'h20, 0, 1, 10);
    rst = 1'b0;
    tick();
    outs("mid rst", 0, 8'h00, 0, 0, 0);
    rst = 1'b1;
    lanes(1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      outs($sformatf("mid idle%0d", i), 0, 8'h00, 0, 0, 0);
    end
    lanes(1'b1, 8'h40, 1'b1, 8'h41);
    tick();
    outs("mid restart 40", 1, 8'h40, 0, 1, 1);
    tick();
    outs("mid restart 41", 1, 8'h41, 0, 1, 2);
    lanes(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    outs("mid end", 0, 8'h00, 0, 0, 2);

    // scoreboarded stream, long enough to saturate the 4-bit counter
    do_reset();
    seen = 0;
    sbq.delete();
    tick();
    mon_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic       bv;
      a  = 8'($urandom);
      b  = 8'($urandom);
      bv = (i % 5) != 4;
      lanes(1'b1, a, bv, b);
      sbq.push_back(a);
      if (bv) sbq.push_back(b);
      tick();
      tick();
      if (!bv || (i % 3) == 2) begin
        lanes(1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        tick();
      end
    end
    lanes(1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 8 && sbq.size() != 0; i++) tick();
    tick();
    tick();
    mon_en = 1'b0;
    chk("sb drained", 32'(sbq.size()), 32'd0);
    chk("sb total16", 32'(bus16.byte_count), 32'd26);
    chk("sb sat4", 32'(bus4.byte_count), 32'd15);
    chk("sb active", 32'(bus16.active), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_unstriping_2l.md
Name: byte_unstriping_2l

Overview:
- Recombines the two byte lanes of the PHY receive path into a single byte stream at clk_2f.
- Sits directly downstream of the per-lane clk_2f retiming flops and feeds the receive-side FIFO/logic.
- Each lane carries one byte per clk_f period, so its data and valid are held stable for two clk_2f cycles.
- Output order is lane0 byte, then lane1 byte. The block also flags lane-order violations and counts bytes delivered.

Parameters:
- DATA_W, 8, width of each lane byte and of the output.
- CNT_W, 16, width of the saturating delivered-byte counter.

Ports:
- clk_2f  input  1  2x lane-rate clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low.
- lane0_data  input  DATA_W  lane 0 byte, stable two clk_2f cycles.
- lane0_valid  input  1  lane 0 byte valid.
- lane1_data  input  DATA_W  lane 1 byte, same timing as lane 0.
- lane1_valid  input  1  lane 1 byte valid.
- data_out  output  DATA_W  recombined byte, registered.
- valid_out  output  1  data_out valid, registered.
- err_out  output  1  one-cycle pulse on a lane-order violation.
- active  output  1  high while a stream is being unstriped (state RUN).
- byte_count  output  CNT_W  bytes delivered since reset; saturates at all-ones.

Behaviour:
- Reset: when reset==0 at a clk_2f edge, all of the following are cleared:
  - outputs: data_out=0, valid_out=0, err_out=0, active=0, byte_count=0;
  - internal state: state=IDLE, phase=0, hold registers=0.
  - Reset mid-stream discards any held lane1 byte.
- States: IDLE and RUN, plus a phase bit used in RUN. phase=0 is the capture phase; phase=1 is the lane1 output phase.
- IDLE:
  - If lane0_valid=1, capture lane0_data, lane1_data and lane1_valid into hold registers. Drive data_out<=lane0_data and valid_out<=1. Go to RUN with phase<=1.
  - Else drive valid_out<=0 and data_out<=0.
  - If lane1_valid=1 while lane0_valid=0, pulse err_out<=1 and stay in IDLE.
- RUN, phase=1:
  - If hold_l1_valid=1, drive data_out<=hold_l1_data and valid_out<=1, then phase<=0.
  - If hold_l1_valid=0 (stream ended on lane0, odd byte count), drive valid_out<=0 and data_out<=0, and go to IDLE.
- RUN, phase=0: behaves exactly as the IDLE capture step.
  - If lane0_valid=1, capture and output lane0, then phase<=1.
  - Otherwise go to IDLE with valid_out<=0.
  - lane1_valid=1 with lane0_valid=0 pulses err_out and the block goes to IDLE.
- Latency: a lane0 byte appears on data_out 1 cycle after the sampling edge; its lane1 partner appears 2 cycles after.
- Gapless throughput: back-to-back lane pairs produce valid_out continuously high.
- active=1 exactly while state==RUN; it is registered together with state.
- byte_count increments by 1 on every cycle valid_out is registered as 1. It holds at 2^CNT_W-1 (no wrap).
- err_out is a pulse, not sticky, and does not affect byte_count.
- Sampling alignment: the block samples lanes on the first clk_2f edge where lane0_valid rises. Upstream guarantees lane transitions align to that phase.

Decomposition:
- Shared PHY package holds:
  - the state encoding constants (ST_IDLE=1'b0, ST_RUN=1'b1);
  - default DATA_W=8;
  - the comma/idle byte constant 8'hBC, for neighbouring blocks.
- No sub-module is required; the hold registers and the saturating counter stay inline.
- Optionally, the counter may be factored as sat_counter (CNT_W parameter, inc, count).

Test Plan:
- Reset: hold reset=0 for 3 cycles with both lanes valid (0xAA, 0x55) -> all outputs 0 and active=0 throughout; release -> first output 0xAA the next cycle.
- Even stream: lane pairs (0x01,0x02), (0x03,0x04), each held 2 cycles -> data_out sequence 01,02,03,04 with valid_out high for 4 consecutive cycles; byte_count=4; active falls one cycle after last valid.
- Odd stream: pairs (0x10,0x11), then (0x12, lane1_valid=0) -> output 10,11,12 then valid_out=0; byte_count=3; state IDLE.
- Lane-order error: lane1_valid=1, lane1_data=0x77, lane0_valid=0 in IDLE -> err_out=1 for exactly 1 cycle, valid_out stays 0, byte_count unchanged.
- Reset mid-stream: assert reset=0 on the cycle after 0x20 is output (0x21 held) -> 0x21 never appears; all outputs 0; next stream restarts from lane0.
- Saturation: CNT_W=4 with 20 bytes streamed -> byte_count stops at 15 and never wraps.
